// File: rtl/i2s_pkg.sv
// Shared constants and the stereo entry type for the I2S capture/buffer path.
package i2s_pkg;

  localparam int unsigned SAMPLE_WIDTH    = 24;
  localparam int unsigned FIFO_DEPTH_LOG2 = 4;

  typedef struct packed {
    logic [SAMPLE_WIDTH-1:0] left;
    logic [SAMPLE_WIDTH-1:0] right;
  } stereo_t;

endpackage

// File: rtl/i2s_fifo_ptr.sv
// Write/read pointer, level and almost-full bookkeeping for the sample FIFO.
// Pointers carry one extra wrap bit so full and empty are distinguishable.
module i2s_fifo_ptr #(
  parameter int unsigned DEPTH_LOG2  = 4,
  parameter int unsigned ALMOST_FULL = 12
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  flush,
  input  logic                  push,
  input  logic                  pop,
  output logic [DEPTH_LOG2-1:0] wr_addr,
  output logic [DEPTH_LOG2-1:0] rd_addr_next,
  output logic                  full,
  output logic [DEPTH_LOG2:0]   level,
  output logic                  almost_full
);

  localparam int unsigned PW = DEPTH_LOG2 + 1;
  localparam logic [PW-1:0] WRAP_ONLY = PW'(1) << DEPTH_LOG2;

  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PW-1:0] level_q, level_d;
  logic          af_q, af_d;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      level_d  = '0;
    end else begin
      wr_ptr_d = wr_ptr_q + PW'(push);
      rd_ptr_d = rd_ptr_q + PW'(pop);
      level_d  = level_q + PW'(push) - PW'(pop);
    end
    af_d = (level_d >= PW'(ALMOST_FULL));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      af_q     <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
      af_q     <= af_d;
    end
  end

  assign full         = ((wr_ptr_q ^ rd_ptr_q) == WRAP_ONLY);
  assign wr_addr      = wr_ptr_q[DEPTH_LOG2-1:0];
  assign rd_addr_next = rd_ptr_d[DEPTH_LOG2-1:0];
  assign level        = level_q;
  assign almost_full  = af_q;

endmodule

// File: rtl/i2s_sample_fifo.sv
// Stereo sample FIFO with registered first-word-fall-through head and sticky overflow.
// Define I2S_SAMPLE_FIFO_OVF_CNT_EN to add the saturating ovf_count_o drop counter.
module i2s_sample_fifo
  import i2s_pkg::*;
#(
  parameter int unsigned WIDTH       = SAMPLE_WIDTH,
  parameter int unsigned DEPTH_LOG2  = FIFO_DEPTH_LOG2,
  parameter int unsigned ALMOST_FULL = 12
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic [WIDTH-1:0]      in_left_i,
  input  logic [WIDTH-1:0]      in_right_i,
  input  logic                  in_valid_i,
  output logic [WIDTH-1:0]      out_left_o,
  output logic [WIDTH-1:0]      out_right_o,
  output logic                  out_valid_o,
  input  logic                  out_ready_i,
  output logic [DEPTH_LOG2:0]   level_o,
  output logic                  almost_full_o,
  output logic                  overflow_o,
  input  logic                  clear_ovf_i,
  input  logic                  flush_i
`ifdef I2S_SAMPLE_FIFO_OVF_CNT_EN
  ,
  output logic [15:0]           ovf_count_o
`endif
);

  localparam int unsigned DEPTH = 1 << DEPTH_LOG2;
  localparam int unsigned EW    = 2 * WIDTH;
  localparam int unsigned PW    = DEPTH_LOG2 + 1;

  logic [EW-1:0]         mem [DEPTH];
  logic [EW-1:0]         out_q, out_d;
  logic                  out_valid_q, out_valid_d;
  logic                  ovf_q, ovf_d;
  logic                  push, pop, drop, full;
  logic [DEPTH_LOG2-1:0] wr_addr, rd_addr_next;
  logic [PW-1:0]         level, remain;

  assign pop  = out_valid_q & out_ready_i;
  assign push = in_valid_i & (~full | pop);
  assign drop = in_valid_i & full & ~pop & ~flush_i;

  i2s_fifo_ptr #(
    .DEPTH_LOG2  (DEPTH_LOG2),
    .ALMOST_FULL (ALMOST_FULL)
  ) u_ptr (
    .clk          (clk_i),
    .rst          (rst_i),
    .flush        (flush_i),
    .push         (push),
    .pop          (pop),
    .wr_addr      (wr_addr),
    .rd_addr_next (rd_addr_next),
    .full         (full),
    .level        (level),
    .almost_full  (almost_full_o)
  );

  always_ff @(posedge clk_i) begin
    if (push && !flush_i) begin
      mem[wr_addr] <= {in_left_i, in_right_i};
    end
  end

  // A push into an empty FIFO surfaces one cycle later; the only bypass is
  // push+pop at level 1, where the slot being written becomes the new head.
  always_comb begin
    remain      = level - PW'(pop);
    out_valid_d = 1'b0;
    out_d       = out_q;
    if (!flush_i) begin
      if (push && pop && (level == PW'(1))) begin
        out_valid_d = 1'b1;
        out_d       = {in_left_i, in_right_i};
      end else if (remain != '0) begin
        out_valid_d = 1'b1;
        out_d       = mem[rd_addr_next];
      end
    end
    ovf_d = drop | (ovf_q & ~clear_ovf_i);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      out_q       <= '0;
      out_valid_q <= 1'b0;
      ovf_q       <= 1'b0;
    end else begin
      out_q       <= out_d;
      out_valid_q <= out_valid_d;
      ovf_q       <= ovf_d;
    end
  end

  assign out_left_o  = out_q[EW-1 -: WIDTH];
  assign out_right_o = out_q[WIDTH-1:0];
  assign out_valid_o = out_valid_q;
  assign level_o     = level;
  assign overflow_o  = ovf_q;

`ifdef I2S_SAMPLE_FIFO_OVF_CNT_EN
  logic [15:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clear_ovf_i) begin
      cnt_d = drop ? 16'd1 : 16'd0;
    end else if (drop && (cnt_q != 16'hFFFF)) begin
      cnt_d = cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign ovf_count_o = cnt_q;
`endif

endmodule

// File: tb/tb_i2s_sample_fifo.sv
// Directed bench for i2s_sample_fifo at DEPTH_LOG2=2, ALMOST_FULL=3, WIDTH=24.
module tb_i2s_sample_fifo;

  localparam int unsigned W  = 24;
  localparam int unsigned DL = 2;

  logic          clk = 1'b0;
  logic          rst;
  logic [W-1:0]  in_left, in_right;
  logic          in_valid;
  logic [W-1:0]  out_left, out_right;
  logic          out_valid;
  logic          out_ready;
  logic [DL:0]   level;
  logic          almost_full;
  logic          overflow;
  logic          clear_ovf;
  logic          flush;
`ifdef I2S_SAMPLE_FIFO_OVF_CNT_EN
  logic [15:0]   ovf_count;
`endif

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  i2s_sample_fifo #(
    .WIDTH       (W),
    .DEPTH_LOG2  (DL),
    .ALMOST_FULL (3)
  ) dut (
    .clk_i         (clk),
    .rst_i         (rst),
    .in_left_i     (in_left),
    .in_right_i    (in_right),
    .in_valid_i    (in_valid),
    .out_left_o    (out_left),
    .out_right_o   (out_right),
    .out_valid_o   (out_valid),
    .out_ready_i   (out_ready),
    .level_o       (level),
    .almost_full_o (almost_full),
    .overflow_o    (overflow),
    .clear_ovf_i   (clear_ovf),
    .flush_i       (flush)
`ifdef I2S_SAMPLE_FIFO_OVF_CNT_EN
    ,
    .ovf_count_o   (ovf_count)
`endif
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_one(input logic [W-1:0] l, input logic [W-1:0] r);
    in_left  = l;
    in_right = r;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
  endtask

  initial begin
    rst = 1'b1; in_left = '0; in_right = '0; in_valid = 1'b0;
    out_ready = 1'b0; clear_ovf = 1'b0; flush = 1'b0;
    tick();
    tick();
    check("rst_valid", 32'(out_valid), 32'd0);
    check("rst_level", 32'(level), 32'd0);
    check("rst_af", 32'(almost_full), 32'd0);
    check("rst_ovf", 32'(overflow), 32'd0);
    check("rst_left", 32'(out_left), 32'd0);
    check("rst_right", 32'(out_right), 32'd0);
`ifdef I2S_SAMPLE_FIFO_OVF_CNT_EN
    check("rst_cnt", 32'(ovf_count), 32'd0);
`endif
    rst = 1'b0;
    tick();

    // Single sample, one-cycle fall-through latency
    push_one(24'h000123, 24'hFFFEDC);
    check("single_lvl_n", 32'(level), 32'd1);
    check("single_vld_n", 32'(out_valid), 32'd0);
    tick();
    check("single_vld", 32'(out_valid), 32'd1);
    check("single_left", 32'(out_left), 32'h000123);
    check("single_right", 32'(out_right), 32'hFFFEDC);
    check("single_lvl", 32'(level), 32'd1);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check("single_pop_vld", 32'(out_valid), 32'd0);
    check("single_pop_lvl", 32'(level), 32'd0);

    // Fill and overflow
    for (int i = 1; i <= 5; i++) begin
      push_one(W'(i), W'(32'h100 + i));
      check($sformatf("fill_lvl%0d", i), 32'(level), (i > 4) ? 32'd4 : 32'(i));
      check($sformatf("fill_af%0d", i), 32'(almost_full), (i >= 3) ? 32'd1 : 32'd0);
      check($sformatf("fill_ovf%0d", i), 32'(overflow), (i == 5) ? 32'd1 : 32'd0);
    end
`ifdef I2S_SAMPLE_FIFO_OVF_CNT_EN
    check("fill_cnt", 32'(ovf_count), 32'd1);
`endif
    for (int j = 1; j <= 4; j++) begin
      check($sformatf("drain_vld%0d", j), 32'(out_valid), 32'd1);
      check($sformatf("drain_left%0d", j), 32'(out_left), 32'(j));
      check($sformatf("drain_right%0d", j), 32'(out_right), 32'h100 + 32'(j));
      out_ready = 1'b1;
      tick();
    end
    out_ready = 1'b0;
    check("drain_vld_end", 32'(out_valid), 32'd0);
    check("drain_lvl_end", 32'(level), 32'd0);
    clear_ovf = 1'b1;
    tick();
    clear_ovf = 1'b0;
    check("clear_ovf", 32'(overflow), 32'd0);
`ifdef I2S_SAMPLE_FIFO_OVF_CNT_EN
    check("clear_cnt", 32'(ovf_count), 32'd0);
`endif

    // Full with simultaneous push+pop
    for (int i = 1; i <= 4; i++) push_one(W'(i), W'(i));
    check("fpp_lvl_pre", 32'(level), 32'd4);
    in_left = 24'd5; in_right = 24'd5; in_valid = 1'b1; out_ready = 1'b1;
    tick();
    in_valid = 1'b0;
    check("fpp_lvl", 32'(level), 32'd4);
    check("fpp_ovf", 32'(overflow), 32'd0);
    for (int j = 2; j <= 5; j++) begin
      check($sformatf("fpp_left%0d", j), 32'(out_left), 32'(j));
      tick();
    end
    out_ready = 1'b0;
    check("fpp_lvl_end", 32'(level), 32'd0);
    check("fpp_vld_end", 32'(out_valid), 32'd0);

    // Pointer wrap with interleaved push/pop
    for (int k = 0; k < 20; k++) begin
      push_one(W'(32'h500 + k), W'(32'hA00 + k));
      tick();
      check($sformatf("wrap_left%0d", k), 32'(out_left), 32'h500 + 32'(k));
      check($sformatf("wrap_right%0d", k), 32'(out_right), 32'hA00 + 32'(k));
      check($sformatf("wrap_lvl%0d", k), 32'(level), 32'd1);
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      check($sformatf("wrap_lvl0_%0d", k), 32'(level), 32'd0);
    end

    // Push+pop at level 1: new entry becomes head, valid stays high
    push_one(24'h0000AA, 24'h0000AB);
    tick();
    in_left = 24'h0000BB; in_right = 24'h0000BC; in_valid = 1'b1; out_ready = 1'b1;
    tick();
    in_valid = 1'b0; out_ready = 1'b0;
    check("l1pp_vld", 32'(out_valid), 32'd1);
    check("l1pp_left", 32'(out_left), 32'h0000BB);
    check("l1pp_right", 32'(out_right), 32'h0000BC);
    check("l1pp_lvl", 32'(level), 32'd1);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check("l1pp_empty", 32'(level), 32'd0);

    // Flush with a concurrent strobe, then clear
    for (int i = 1; i <= 5; i++) push_one(W'(i), W'(i));
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check("fl_lvl_pre", 32'(level), 32'd3);
    check("fl_ovf_pre", 32'(overflow), 32'd1);
    flush = 1'b1; in_valid = 1'b1; in_left = 24'h77;
    tick();
    flush = 1'b0; in_valid = 1'b0;
    check("fl_lvl", 32'(level), 32'd0);
    check("fl_vld", 32'(out_valid), 32'd0);
    check("fl_ovf", 32'(overflow), 32'd1);
    check("fl_af", 32'(almost_full), 32'd0);
    clear_ovf = 1'b1;
    tick();
    clear_ovf = 1'b0;
    check("fl_clear", 32'(overflow), 32'd0);
    check("fl_lvl_after", 32'(level), 32'd0);
    check("fl_vld_after", 32'(out_valid), 32'd0);

    // Reset mid-stream with a strobe on the reset edge
    push_one(24'd1, 24'd1);
    push_one(24'd2, 24'd2);
    check("mid_lvl_pre", 32'(level), 32'd2);
    rst = 1'b1; in_valid = 1'b1;
    tick();
    rst = 1'b0; in_valid = 1'b0;
    check("mid_lvl", 32'(level), 32'd0);
    check("mid_vld", 32'(out_valid), 32'd0);
    check("mid_left", 32'(out_left), 32'd0);
    check("mid_right", 32'(out_right), 32'd0);
    check("mid_ovf", 32'(overflow), 32'd0);
    push_one(24'h7, 24'h8);
    check("mid_push_vld_n", 32'(out_valid), 32'd0);
    tick();
    check("mid_push_vld", 32'(out_valid), 32'd1);
    check("mid_push_left", 32'(out_left), 32'h7);

    // Two drops, then a drop coinciding with clear (set wins)
    for (int i = 0; i < 5; i++) push_one(W'(32'h10 + i), '0);
    check("dd_ovf", 32'(overflow), 32'd1);
    check("dd_head", 32'(out_left), 32'h7);
`ifdef I2S_SAMPLE_FIFO_OVF_CNT_EN
    check("dd_cnt", 32'(ovf_count), 32'd2);
`endif
    clear_ovf = 1'b1; in_valid = 1'b1;
    tick();
    clear_ovf = 1'b0; in_valid = 1'b0;
    check("dc_ovf", 32'(overflow), 32'd1);
    check("dc_lvl", 32'(level), 32'd4);
`ifdef I2S_SAMPLE_FIFO_OVF_CNT_EN
    check("dc_cnt", 32'(ovf_count), 32'd1);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
